ir_dir_decoder: RTL and testbench
=================================

# ir_dir_decoder

Converts the 32-bit NEC frame word produced by the IR receiver into snake direction commands for the game core. It detects each newly completed frame, checks the address and command complements, and maps the four arrow keys to a 2-bit direction. It buffers one pending request and commits it on the game's step tick, rejecting 180° reversals. It sits between the IR receiver and the snake movement logic, in the same clock domain as the receiver.

## Interface
- ADDR, 8'h20, expected NEC address byte (word[31:24]); word[23:16] must equal ~ADDR
- CMD_UP, 8'h6A, command byte for up
- CMD_DOWN, 8'hEA, command byte for down
- CMD_LEFT, 8'h1A, command byte for left
- CMD_RIGHT, 8'h9A, command byte for right
- INIT_DIR, DIR_RIGHT, direction loaded at reset
- nec_clk  in  1  block clock, same clock as the IR receiver
- reset_n  in  1  asynchronous, active-low reset
- word  in  32  latest frame from the IR receiver; changes only when a frame completes
- tick  in  1  one-cycle game step strobe; commits the pending request
- dir  out  2  current committed direction (dir_t); reset INIT_DIR
- dir_changed  out  1  one-cycle pulse when dir takes a new value; reset 0
- cmd_valid  out  1  one-cycle pulse when a valid arrow-key frame is accepted; reset 0
- cmd_error  out  1  one-cycle pulse when a frame fails a complement check; reset 0
- err_count  out  8  count of cmd_error pulses, saturates at 255; reset 0

## Operation
- Direction encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3. The opposite direction is the value with bit0 inverted.
- Frame detection:
  - word_q is reset to 32'h0.
  - A new frame exists on any clock edge where word != word_q. On that edge: word_q <= word, frame_q <= word.
  - Because the receiver has no valid strobe, a repeat press of the same key (identical word) is not seen. This is acceptable.
- FSM states and transitions:
  - IDLE: on a new frame go to DECODE.
  - DECODE: classify frame_q and always return to IDLE.
  - A new frame that arrives while in DECODE is captured on that edge and decoded on the next pass; no frame is dropped.
- Classification in DECODE:
  - Error: word[31:24] != ADDR, or word[23:16] != ~ADDR, or word[7:0] != ~word[15:8]. Effects: cmd_error pulse, err_count +1 (saturating), pending unchanged.
  - Valid arrow key (cmd matches one of CMD_UP/DOWN/LEFT/RIGHT): cmd_valid pulse; pend_dir <= mapped direction; pend_vld <= 1. A newer request overwrites an older pending one.
  - Valid frame with an unrecognised command: silently ignored, no pulses.
- Commit on tick while pend_vld:
  - If pend_dir == opposite(dir): reject and leave dir unchanged.
  - Else if pend_dir != dir: dir <= pend_dir and pulse dir_changed.
  - Else (same direction): no change, no pulse.
  - pend_vld <= 0 in every case.
- tick while !pend_vld: no effect.
- The reversal check uses dir at commit time, not at request time.

## Timing
- Word change seen at edge k → FSM in DECODE after edge k → cmd_valid/cmd_error high for the cycle after edge k+1. Latency is 2 cycles from word change to pulse.
- Earliest commit: a tick sampled at edge k+2 updates dir after edge k+2.
- tick coincident with a DECODE that sets pending (edge k+1): the tick commits the old pending state (or nothing), then the new request becomes pending. pend_vld ends at 1.
- tick and reset together: reset wins.
- Reset mid-DECODE: the FSM returns to IDLE, all pulses go to 0, and pending is cleared. Since word_q resets to 0, a still-held nonzero word is re-detected and re-decoded after reset release.
- All outputs are registered. Pulses are exactly one cycle wide.

## Structure
- snake_pkg holds: dir_t enum (DIR_UP/DOWN/LEFT/RIGHT), function opposite(dir_t), NEC default address/command constants, and the FSM state enum.
- One sub-module, nec_frame_check: combinational classifier (frame → is_err, is_arrow, dir_t). It is reused by any future IR-driven menu logic.

## Test plan
- Reset, then word=32'h20DF6A95 → cmd_valid pulse 2 cycles later; tick → dir=UP, dir_changed pulse.
- dir=UP, word=32'h20DFEA15 (DOWN), tick → dir stays UP, no dir_changed, pend_vld cleared.
- word=32'h20DF1AE5 then, before any tick, word=32'h20DF9A65 (dir=UP) → two cmd_valid pulses; tick → dir=RIGHT (last request wins).
- word=32'h20DF6A94 (bad complement) → cmd_error pulse, err_count=1, dir unchanged. 256 distinct bad frames → err_count stays at 255.
- word=32'h20DF02FD (valid, unknown command) → no pulses; a following tick leaves dir unchanged.
- tick asserted on the same edge pending is set (dir=RIGHT, request UP) → dir unchanged that edge; next tick → dir=UP. Assert reset_n low mid-DECODE → all outputs return to reset values and the held word is redecoded after release.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and NEC constants for the IR-driven snake direction path.
// Direction encoding puts opposite keys on the same bit1 value, so a reversal only flips bit0.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_DECODE = 1'b1
   } state_t;

   localparam logic [7:0] NEC_ADDR      = 8'h20;
   localparam logic [7:0] NEC_CMD_UP    = 8'h6A;
   localparam logic [7:0] NEC_CMD_DOWN  = 8'hEA;
   localparam logic [7:0] NEC_CMD_LEFT  = 8'h1A;
   localparam logic [7:0] NEC_CMD_RIGHT = 8'h9A;

   function automatic dir_t opposite(input dir_t d);
      return dir_t'({d[1], ~d[0]});
   endfunction

endpackage

// File: rtl/nec_frame_check.sv
// Combinational NEC frame classifier: complement checks plus arrow-key lookup.
// Kept free of state so menu logic can share it later.
module nec_frame_check
   import snake_pkg::*;
#(
   parameter logic [7:0] ADDR      = NEC_ADDR,
   parameter logic [7:0] CMD_UP    = NEC_CMD_UP,
   parameter logic [7:0] CMD_DOWN  = NEC_CMD_DOWN,
   parameter logic [7:0] CMD_LEFT  = NEC_CMD_LEFT,
   parameter logic [7:0] CMD_RIGHT = NEC_CMD_RIGHT
) (
   input  logic [31:0] frame,
   output logic        is_err,
   output logic        is_arrow,
   output dir_t        dir
);

   logic [7:0] addr_byte;
   logic [7:0] addr_inv;
   logic [7:0] cmd_byte;
   logic [7:0] cmd_inv;

   assign addr_byte = frame[31:24];
   assign addr_inv  = frame[23:16];
   assign cmd_byte  = frame[15:8];
   assign cmd_inv   = frame[7:0];

   always_comb begin
      is_err   = (addr_byte != ADDR) || (addr_inv != ~ADDR) || (cmd_inv != ~cmd_byte);
      is_arrow = 1'b0;
      dir      = DIR_UP;
      if (cmd_byte == CMD_UP) begin
         is_arrow = 1'b1;
         dir      = DIR_UP;
      end else if (cmd_byte == CMD_DOWN) begin
         is_arrow = 1'b1;
         dir      = DIR_DOWN;
      end else if (cmd_byte == CMD_LEFT) begin
         is_arrow = 1'b1;
         dir      = DIR_LEFT;
      end else if (cmd_byte == CMD_RIGHT) begin
         is_arrow = 1'b1;
         dir      = DIR_RIGHT;
      end
   end

endmodule

// File: rtl/ir_dir_decoder.sv
// Turns completed NEC frames into snake direction commands, with one pending
// request committed on the game step tick and 180-degree reversals rejected.
module ir_dir_decoder
   import snake_pkg::*;
#(
   parameter logic [7:0] ADDR      = NEC_ADDR,
   parameter logic [7:0] CMD_UP    = NEC_CMD_UP,
   parameter logic [7:0] CMD_DOWN  = NEC_CMD_DOWN,
   parameter logic [7:0] CMD_LEFT  = NEC_CMD_LEFT,
   parameter logic [7:0] CMD_RIGHT = NEC_CMD_RIGHT,
   parameter dir_t       INIT_DIR  = DIR_RIGHT
) (
   input  logic        nec_clk,
   input  logic        reset_n,
   input  logic [31:0] word,
   input  logic        tick,
   output dir_t        dir,
   output logic        dir_changed,
   output logic        cmd_valid,
   output logic        cmd_error,
   output logic [7:0]  err_count
);

   logic [31:0] word_q;
   logic [31:0] frame_q;
   logic        fresh_q;
   logic        new_frame;
   state_t      state_q;
   state_t      state_next;
   logic        decode_en;
   logic        is_err;
   logic        is_arrow;
   dir_t        frame_dir;
   logic        pend_vld;
   dir_t        pend_dir;

   assign new_frame = (word != word_q);

   nec_frame_check #(
      .ADDR      (ADDR),
      .CMD_UP    (CMD_UP),
      .CMD_DOWN  (CMD_DOWN),
      .CMD_LEFT  (CMD_LEFT),
      .CMD_RIGHT (CMD_RIGHT)
   ) u_check (
      .frame    (frame_q),
      .is_err   (is_err),
      .is_arrow (is_arrow),
      .dir      (frame_dir)
   );

   // fresh_q remembers a frame captured during DECODE so it gets its own pass.
   always_ff @(posedge nec_clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q  <= 32'h0;
         frame_q <= 32'h0;
         fresh_q <= 1'b0;
      end else begin
         if (new_frame) begin
            word_q  <= word;
            frame_q <= word;
         end
         if (state_q == ST_DECODE)
            fresh_q <= new_frame;
         else
            fresh_q <= 1'b0;
      end
   end

   always_ff @(posedge nec_clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_next;
   end

   always_comb begin
      state_next = state_q;
      decode_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (new_frame || fresh_q)
               state_next = ST_DECODE;
         end
         ST_DECODE: begin
            decode_en  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge nec_clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_valid <= 1'b0;
         cmd_error <= 1'b0;
         err_count <= 8'h0;
      end else begin
         cmd_valid <= decode_en && !is_err && is_arrow;
         cmd_error <= decode_en && is_err;
         if (decode_en && is_err && (err_count != 8'hFF))
            err_count <= err_count + 8'h1;
      end
   end

   // Commit first, then a same-edge decode overwrites the pending slot.
   always_ff @(posedge nec_clk or negedge reset_n) begin
      if (!reset_n) begin
         dir         <= INIT_DIR;
         dir_changed <= 1'b0;
         pend_vld    <= 1'b0;
         pend_dir    <= INIT_DIR;
      end else begin
         dir_changed <= 1'b0;
         if (tick && pend_vld) begin
            if ((pend_dir != opposite(dir)) && (pend_dir != dir)) begin
               dir         <= pend_dir;
               dir_changed <= 1'b1;
            end
            pend_vld <= 1'b0;
         end
         if (decode_en && !is_err && is_arrow) begin
            pend_dir <= frame_dir;
            pend_vld <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ir_dir_decoder.sv
// Self-checking bench: directed test-plan scenarios plus randomized frames,
// compared every cycle against a queue-based behavioural model.
module tb_ir_dir_decoder;

   logic        nec_clk;
   logic        reset_n;
   logic [31:0] word;
   logic        tick;
   logic [1:0]  dir;
   logic        dir_changed;
   logic        cmd_valid;
   logic        cmd_error;
   logic [7:0]  err_count;

   int n_vec;
   int n_miss;
   bit chk_en;

   ir_dir_decoder dut (
      .nec_clk     (nec_clk),
      .reset_n     (reset_n),
      .word        (word),
      .tick        (tick),
      .dir         (dir),
      .dir_changed (dir_changed),
      .cmd_valid   (cmd_valid),
      .cmd_error   (cmd_error),
      .err_count   (err_count)
   );

   initial nec_clk = 1'b0;
   always #5 nec_clk = ~nec_clk;

   // Behavioural model: each captured frame gets a decode slot one cycle later,
   // or two cycles after the previous slot when frames arrive back to back.
   typedef struct {
      int          due;
      logic [31:0] f;
   } job_t;

   job_t        m_q[$];
   int          m_cyc;
   int          m_last_due;
   logic [31:0] m_word_q;
   int          m_dir;
   bit          m_pend_vld;
   int          m_pend_dir;
   int          m_err;
   bit          m_valid_p;
   bit          m_error_p;
   bit          m_changed_p;

   function automatic int classify(input logic [31:0] f);
      logic [7:0] a, ai, c, ci;
      a  = f[31:24];
      ai = f[23:16];
      c  = f[15:8];
      ci = f[7:0];
      if (a != 8'h20 || ai != 8'hDF || ci != (8'hFF - c)) return -1;
      case (c)
         8'h6A:   return 0;
         8'hEA:   return 1;
         8'h1A:   return 2;
         8'h9A:   return 3;
         default: return -2;
      endcase
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_cyc       = 0;
      m_last_due  = -10;
      m_word_q    = 32'h0;
      m_dir       = 3;
      m_pend_vld  = 0;
      m_pend_dir  = 0;
      m_err       = 0;
      m_valid_p   = 0;
      m_error_p   = 0;
      m_changed_p = 0;
   endtask

   task automatic model_step();
      job_t j;
      int   r;
      int   due;
      m_valid_p   = 0;
      m_error_p   = 0;
      m_changed_p = 0;
      if (tick && m_pend_vld) begin
         if (m_pend_dir != (m_dir ^ 1) && m_pend_dir != m_dir) begin
            m_dir       = m_pend_dir;
            m_changed_p = 1;
         end
         m_pend_vld = 0;
      end
      if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
         j = m_q.pop_front();
         r = classify(j.f);
         if (r == -1) begin
            m_error_p = 1;
            if (m_err < 255) m_err++;
         end else if (r >= 0) begin
            m_valid_p  = 1;
            m_pend_dir = r;
            m_pend_vld = 1;
         end
      end
      if (word != m_word_q) begin
         m_word_q   = word;
         due        = (m_cyc + 1 > m_last_due + 2) ? m_cyc + 1 : m_last_due + 2;
         j.due      = due;
         j.f        = word;
         m_q.push_back(j);
         m_last_due = due;
      end
      m_cyc++;
   endtask

   always @(posedge nec_clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else          model_step();
   end

   task automatic cmp(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_miss++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   // Per-cycle compare, sampled well after the active edge.
   always @(posedge nec_clk) begin
      #3;
      if (chk_en) begin
         cmp("dir",         int'(dir),         m_dir);
         cmp("dir_changed", int'(dir_changed), int'(m_changed_p));
         cmp("cmd_valid",   int'(cmd_valid),   int'(m_valid_p));
         cmp("cmd_error",   int'(cmd_error),   int'(m_error_p));
         cmp("err_count",   int'(err_count),   m_err);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge nec_clk);
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      @(negedge nec_clk);
      tick = 1'b0;
   endtask

   function automatic logic [31:0] frame_of(input logic [7:0] c);
      return {8'h20, 8'hDF, c, ~c};
   endfunction

   logic [7:0] arrow_tab [4];

   initial begin
      logic [7:0] c;
      logic [7:0] bi;
      n_vec   = 0;
      n_miss  = 0;
      chk_en  = 0;
      word    = 32'h0;
      tick    = 1'b0;
      reset_n = 1'b0;
      arrow_tab[0] = 8'h6A;
      arrow_tab[1] = 8'hEA;
      arrow_tab[2] = 8'h1A;
      arrow_tab[3] = 8'h9A;
      cycles(3);
      cmp("rst_dir",       int'(dir),       3);
      cmp("rst_cmd_valid", int'(cmd_valid), 0);
      cmp("rst_err_count", int'(err_count), 0);
      reset_n = 1'b1;
      chk_en  = 1;
      cycles(2);

      // UP frame: pulse two cycles after the word change, then tick commits
      word = 32'h20DF6A95;
      cycles(1);
      cmp("up_latency_early", int'(cmd_valid), 0);
      cycles(1);
      cmp("up_cmd_valid", int'(cmd_valid), 1);
      pulse_tick();
      cmp("up_dir",         int'(dir),         0);
      cmp("up_dir_changed", int'(dir_changed), 1);
      cycles(2);

      // DOWN while UP is a reversal: rejected
      word = 32'h20DFEA15;
      cycles(3);
      pulse_tick();
      cmp("rev_dir",         int'(dir),         0);
      cmp("rev_dir_changed", int'(dir_changed), 0);
      pulse_tick();
      cmp("rev_cleared_dir", int'(dir), 0);
      cycles(2);

      // LEFT then RIGHT before any tick: last request wins
      word = 32'h20DF1AE5;
      cycles(4);
      word = 32'h20DF9A65;
      cycles(4);
      pulse_tick();
      cmp("last_wins_dir", int'(dir), 3);
      cycles(2);

      // bad complement, then saturation
      word = 32'h20DF6A94;
      cycles(2);
      cmp("bad_cmd_error", int'(cmd_error), 1);
      cmp("bad_err_count", int'(err_count), 1);
      cmp("bad_dir",       int'(dir),       3);
      for (int i = 0; i < 256; i++) begin
         bi   = 8'(i);
         word = {16'h20DF, bi, ~bi ^ 8'h02};
         cycles(3);
      end
      cmp("sat_err_count", int'(err_count), 255);

      // valid frame, unknown command
      word = 32'h20DF02FD;
      cycles(2);
      cmp("unk_cmd_valid", int'(cmd_valid), 0);
      cmp("unk_cmd_error", int'(cmd_error), 0);
      cycles(1);
      pulse_tick();
      cmp("unk_dir", int'(dir), 3);
      cycles(2);

      // tick on the edge that sets pending: old (empty) pending commits
      word = 32'h20DF6A95;
      cycles(1);
      tick = 1'b1;
      cycles(1);
      tick = 1'b0;
      cmp("coinc_cmd_valid", int'(cmd_valid), 1);
      cmp("coinc_dir",       int'(dir),       3);
      pulse_tick();
      cmp("coinc_next_dir", int'(dir), 0);
      cycles(2);

      // back-to-back frames: second one decoded on the following pass
      word = 32'h20DFEA15;
      cycles(1);
      word = 32'h20DF1AE5;
      cycles(4);
      pulse_tick();
      cmp("b2b_dir", int'(dir), 2);
      cycles(2);

      // reset mid-DECODE, held word redecoded after release
      word = 32'h20DF9A65;
      cycles(1);
      reset_n = 1'b0;
      cycles(1);
      cmp("mid_rst_dir",       int'(dir),       3);
      cmp("mid_rst_cmd_valid", int'(cmd_valid), 0);
      cmp("mid_rst_err_count", int'(err_count), 0);
      reset_n = 1'b1;
      cycles(2);
      cmp("redecode_cmd_valid", int'(cmd_valid), 1);
      cycles(2);

      // randomized frames, at least 3 cycles apart
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 4))
            0, 1: word = frame_of(arrow_tab[$urandom_range(0, 3)]);
            2: begin
               c    = 8'($urandom);
               word = {16'h20DF, c, ~c ^ 8'($urandom_range(1, 255))};
            end
            3: word = frame_of(8'($urandom));
            default: word = $urandom;
         endcase
         for (int k = 0; k < int'($urandom_range(3, 6)); k++) begin
            tick = ($urandom_range(0, 2) == 0);
            @(negedge nec_clk);
         end
         tick = 1'b0;
      end
      cycles(4);

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
